// File: rtl/lut_settle_eval.sv
// lut_settle_eval: reconfigurable lookup-table evaluator with input settling.
//
// The block evaluates a 2^N_IN-entry truth table against N_IN logic inputs,
// but only after the inputs have been stable for SETTLE consecutive edges.
// The output for input value i is table bit (2^N_IN-1-i), so the MSB of the
// table holds the result for input 0.
//
// A serial configuration port loads a new table one bit per beat, MSB-first
// (first beat is the bit for input 0). Beats land in a shadow register; the
// active table is only replaced in a one-cycle COMMIT state after a correctly
// framed load (cfg_last exactly on the final beat). Any framing error sets a
// sticky err flag and discards the shadow, leaving the active table intact.
//
// Handshake: a configuration beat transfers on a rising edge where
// cfg_valid && cfg_ready are both high. cfg_ready is registered and is low
// only during the single COMMIT cycle. cfg_valid may drop between beats for
// any number of cycles; the partial load simply waits.
module lut_settle_eval #(
  parameter int N_IN = 3,
  parameter int SETTLE = 4,
  parameter logic [(1<<N_IN)-1:0] INIT_TABLE = 8'hCD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] in,
  input  logic            cfg_valid,
  input  logic            cfg_data,
  input  logic            cfg_last,
  output logic            cfg_ready,
  output logic            out,
  output logic            out_valid,
  output logic            err
);

  localparam int W  = 1 << N_IN;
  localparam int CW = $clog2(SETTLE + 1);
  localparam int BW = N_IN + 1;

  localparam logic [CW-1:0] SETTLE_C    = CW'(SETTLE);
  localparam logic [CW-1:0] SETTLE_M1   = CW'(SETTLE - 1);
  localparam logic [BW-1:0] LAST_BEAT   = BW'(W - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_t;

  cfg_state_t       state;
  logic [W-1:0]     lut_q;
  logic [W-1:0]     shadow;
  logic [BW-1:0]    beat_cnt;
  logic [N_IN-1:0]  in_q;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             commit;
  logic             last_beat;
  logic             frame_err;
  logic             in_changed;
  logic [N_IN-1:0]  lut_idx;
  logic             lut_bit;

  // Beat transfer and framing decode.
  assign accept     = cfg_valid & cfg_ready;
  assign commit     = (state == COMMIT);
  assign last_beat  = (beat_cnt == LAST_BEAT);
  // Error when cfg_last disagrees with whether this is the final beat.
  assign frame_err  = accept & (cfg_last ^ last_beat);

  // Table lookup: entry for input i sits at bit (W-1-i), which for an
  // N_IN-bit index is simply the bitwise inverse of i.
  assign in_changed = (in != in_q);
  assign lut_idx    = ~in_q;
  assign lut_bit    = lut_q[lut_idx];

  // Configuration FSM: collects beats into the shadow and commits the table.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      cfg_ready <= 1'b1;
      lut_q     <= INIT_TABLE;
      shadow    <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        RUN, LOAD: begin
          if (accept) begin
            if (frame_err) begin
              // Bad framing: drop the partial load, keep the active table.
              err      <= 1'b1;
              shadow   <= '0;
              beat_cnt <= '0;
              state    <= RUN;
            end else if (last_beat) begin
              shadow    <= {shadow[W-2:0], cfg_data};
              state     <= COMMIT;
              cfg_ready <= 1'b0;
            end else begin
              shadow   <= {shadow[W-2:0], cfg_data};
              beat_cnt <= beat_cnt + BW'(1);
              state    <= LOAD;
            end
          end
        end
        COMMIT: begin
          lut_q     <= shadow;
          shadow    <= '0;
          beat_cnt  <= '0;
          state     <= RUN;
          cfg_ready <= 1'b1;
        end
        default: begin
          state     <= RUN;
          cfg_ready <= 1'b1;
          shadow    <= '0;
          beat_cnt  <= '0;
        end
      endcase
    end
  end

  // Input settling and output evaluation against the active table.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q      <= '0;
      cnt       <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (in_changed) begin
        // New input value restarts the settle window; out keeps its value.
        // A commit on the same edge needs nothing extra: cnt clears anyway.
        in_q      <= in;
        cnt       <= '0;
        out_valid <= 1'b0;
      end else if (commit) begin
        // Table is being replaced: restart the settle window so out is
        // re-evaluated against the new table.
        cnt       <= '0;
        out_valid <= 1'b0;
      end else if (cnt < SETTLE_C) begin
        cnt <= cnt + CW'(1);
        if (cnt == SETTLE_M1) begin
          out       <= lut_bit;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lut_settle_eval.sv
// Directed testbench for lut_settle_eval: default instance (N_IN=3,
// SETTLE=4, table 8'hCD) and a wide/fast instance (N_IN=4, SETTLE=1).
module tb_lut_settle_eval;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: defaults
  logic       rst0 = 1'b1;
  logic [2:0] in0  = 3'b000;
  logic       cv0  = 1'b0;
  logic       cd0  = 1'b0;
  logic       cl0  = 1'b0;
  logic       rdy0, out0, ov0, err0;

  // Instance 1: N_IN=4, SETTLE=1
  logic       rst1 = 1'b1;
  logic [3:0] in1  = 4'b0000;
  logic       cv1  = 1'b0;
  logic       cd1  = 1'b0;
  logic       cl1  = 1'b0;
  logic       rdy1, out1, ov1, err1;

  lut_settle_eval dut0 (
    .clk       (clk),
    .reset     (rst0),
    .in        (in0),
    .cfg_valid (cv0),
    .cfg_data  (cd0),
    .cfg_last  (cl0),
    .cfg_ready (rdy0),
    .out       (out0),
    .out_valid (ov0),
    .err       (err0)
  );

  lut_settle_eval #(
    .N_IN       (4),
    .SETTLE     (1),
    .INIT_TABLE (16'hA5F0)
  ) dut1 (
    .clk       (clk),
    .reset     (rst1),
    .in        (in1),
    .cfg_valid (cv1),
    .cfg_data  (cd1),
    .cfg_last  (cl1),
    .cfg_ready (rdy1),
    .out       (out1),
    .out_valid (ov1),
    .err       (err1)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance n rising edges; returns 1 time unit after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    cv0 = 1'b0; cl0 = 1'b0; cd0 = 1'b0;
    tick(2);
    rst0 = 1'b0;
  endtask

  // Send nbeats of val MSB-first on instance 0; cfg_last on beat last_at
  // (1-based, 0 = never).
  task automatic send0(input logic [7:0] val, input int nbeats, input int last_at);
    for (int k = 0; k < nbeats; k++) begin
      cv0 = 1'b1;
      cd0 = val[7-k];
      cl0 = (k + 1 == last_at);
      tick(1);
    end
    cv0 = 1'b0; cl0 = 1'b0; cd0 = 1'b0;
  endtask

  task automatic send1(input logic [15:0] val);
    for (int k = 0; k < 16; k++) begin
      cv1 = 1'b1;
      cd1 = val[15-k];
      cl1 = (k == 15);
      tick(1);
    end
    cv1 = 1'b0; cl1 = 1'b0; cd1 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state and first evaluation with defaults, in=000
    reset0();
    check("rst_out", out0, 0);
    check("rst_ov", ov0, 0);
    check("rst_err", err0, 0);
    check("rst_rdy", rdy0, 1);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      check("boot_ov_low", ov0, 0);
      check("boot_out_low", out0, 0);
    end
    tick(1);
    check("boot_out", out0, 1);
    check("boot_ov", ov0, 1);

    // in=010 held: out_valid drops next edge, out=0 on 5th edge
    in0 = 3'b010;
    tick(1);
    check("chg_ov_drop", ov0, 0);
    check("chg_out_hold", out0, 1);
    tick(3);
    check("chg_ov_wait", ov0, 0);
    tick(1);
    check("chg_out", out0, 0);
    check("chg_ov", ov0, 1);

    // 2-cycle glitch to 111 must not reach out
    in0 = 3'b111;
    tick(2);
    check("glitch_out_a", out0, 0);
    in0 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("glitch_out_b", out0, 0);
    end
    check("glitch_ov", ov0, 1);

    // Settle on 111 with the old table
    in0 = 3'b111;
    tick(5);
    check("pre_load_out", out0, 1);
    check("pre_load_ov", ov0, 1);

    // Load 8'h01 with a pause mid-load; evaluation continues meanwhile
    send0(8'h01, 3, 0);
    tick(3);
    check("pause_rdy", rdy0, 1);
    check("load_ov_hold", ov0, 1);
    cv0 = 1'b1; cd0 = 1'b0; cl0 = 1'b0;
    for (int k = 3; k < 8; k++) begin
      cd0 = (k == 7);
      cl0 = (k == 7);
      tick(1);
    end
    cv0 = 1'b0; cl0 = 1'b0; cd0 = 1'b0;
    check("commit_rdy", rdy0, 0);
    tick(1);
    check("post_commit_rdy", rdy0, 1);
    check("post_commit_ov", ov0, 0);
    tick(3);
    check("commit_settle_ov", ov0, 0);
    tick(1);
    check("new_tbl_111", out0, 1);
    check("new_tbl_111_ov", ov0, 1);
    in0 = 3'b000;
    tick(5);
    check("new_tbl_000", out0, 0);
    check("no_err_good_load", err0, 0);

    // Framing error: cfg_last on beat 5
    in0 = 3'b000;
    reset0();
    tick(4);
    check("fe_base_out", out0, 1);
    send0(8'hF8, 5, 5);
    check("fe_err", err0, 1);
    check("fe_rdy", rdy0, 1);
    in0 = 3'b010;
    tick(5);
    check("fe_tbl_010", out0, 0);
    in0 = 3'b000;
    tick(5);
    check("fe_tbl_000", out0, 1);
    // A valid load still works; err stays set
    send0(8'h01, 8, 8);
    check("fe_reload_rdy", rdy0, 0);
    tick(5);
    check("fe_reload_out", out0, 0);
    check("fe_err_sticky", err0, 1);

    // Framing error: cfg_last missing on beat 8
    reset0();
    check("fe2_err_clear", err0, 0);
    send0(8'hFF, 8, 0);
    check("fe2_err", err0, 1);
    check("fe2_rdy", rdy0, 1);
    tick(1);
    check("fe2_rdy_stay", rdy0, 1);

    // Reset mid-load aborts; next load needs a full 8 beats
    reset0();
    tick(4);
    send0(8'hE0, 3, 0);
    check("abort_rdy_pre", rdy0, 1);
    reset0();
    check("abort_rdy", rdy0, 1);
    check("abort_err", err0, 0);
    check("abort_ov", ov0, 0);
    tick(4);
    check("abort_tbl", out0, 1);
    send0(8'h00, 8, 8);
    check("abort_full_rdy", rdy0, 0);
    check("abort_full_err", err0, 0);
    tick(5);
    check("abort_full_out", out0, 0);
    check("abort_full_ov", ov0, 1);

    // ---- Instance 1: N_IN=4, SETTLE=1, table 16'hA5F0 ----
    in1 = 4'd0;
    rst1 = 1'b1;
    tick(2);
    rst1 = 1'b0;
    check("w_rst_ov", ov1, 0);
    tick(1);
    check("w_boot_out", out1, 1);
    check("w_boot_ov", ov1, 1);
    in1 = 4'd8;
    tick(1);
    check("w_chg_ov", ov1, 0);
    tick(1);
    check("w_old_8", out1, 1);
    check("w_old_8_ov", ov1, 1);
    send1(16'h8001);
    check("w_commit_rdy", rdy1, 0);
    tick(1);
    check("w_commit_ov", ov1, 0);
    check("w_commit_rdy1", rdy1, 1);
    tick(1);
    check("w_new_8", out1, 0);
    check("w_new_8_ov", ov1, 1);
    in1 = 4'd15;
    tick(1);
    check("w_15_hold", out1, 0);
    tick(1);
    check("w_new_15", out1, 1);
    in1 = 4'd5;
    tick(2);
    check("w_new_5", out1, 0);
    in1 = 4'd0;
    tick(2);
    check("w_new_0", out1, 1);
    check("w_err", err1, 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
